bnn_mem_responder: RTL



---
 rtl/bnn_mem_pkg.sv | 31 +++
 rtl/bnn_mem_bank.sv | 54 +++++
 rtl/bnn_mem_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bnn_mem_pkg.sv
// ============================================================================
// Module   : bnn_mem_pkg
// Purpose  : Shared command codes, FSM encodings and default widths for the
//            BNN weight/activation memory responder and its compute engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_mem_pkg;

    // Default widths shared with the compute engine
    localparam int DEF_ADDR_LEN = 10;
    localparam int DEF_DATA_LEN = 1;
    localparam int DEF_SEL_LEN  = 2;
    localparam int DEF_RW_LEN   = 2;

    // Command encodings on the rw bus
    localparam logic [DEF_RW_LEN-1:0] RW_IDLE  = 2'b00;
    localparam logic [DEF_RW_LEN-1:0] RW_READ  = 2'b01;
    localparam logic [DEF_RW_LEN-1:0] RW_WRITE = 2'b10;
    localparam logic [DEF_RW_LEN-1:0] RW_RSVD  = 2'b11;

    // Responder FSM: zero-fill after reset, then serve commands
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

endpackage : bnn_mem_pkg

`default_nettype wire

// File: rtl/bnn_mem_bank.sv
// ============================================================================
// Module   : bnn_mem_bank
// Purpose  : One single-port memory bank. Synchronous write, registered read,
//            plus a clear-write port used by the post-reset zero fill. The
//            clear port has priority over the normal write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_mem_bank
    import bnn_mem_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_en,
    input  logic [ADDR_LEN-1:0] clr_addr,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata
);

    localparam int c_depth = 2 ** ADDR_LEN;

    logic [DATA_LEN-1:0] r_mem [c_depth];
    logic [DATA_LEN-1:0] r_rdata;

    // Storage array: zero fill wins over an ordinary write
    always_ff @(posedge clk) begin
        if (clr_en) begin
            r_mem[clr_addr] <= '0;
        end else if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read register: updates only on a read so the value holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule : bnn_mem_bank

`default_nettype wire

// File: rtl/bnn_mem_responder.sv
// ============================================================================
// Module   : bnn_mem_responder
// Purpose  : Memory-side responder for the BNN compute engine. Holds NBANK
//            banks of DATA_LEN-bit words, zero-fills them after reset, then
//            services one read/write command per cycle.
// Options  : MEM_READ_PIPE2_EN - adds an output register stage, read latency 2
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_mem_responder
    import bnn_mem_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int SEL_LEN  = DEF_SEL_LEN,
    parameter int RW_LEN   = DEF_RW_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [SEL_LEN-1:0]  sel,
    input  logic [RW_LEN-1:0]   rw,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata,
    output logic                rdata_valid,
    output logic                ready,
    output logic                err
);

    localparam int c_nbank = 2 ** SEL_LEN;

    state_t              r_state;
    logic [ADDR_LEN-1:0] r_clr_cnt;
    logic                r_ready;
    logic                r_err;
    logic                r_rd_vld;
    logic [SEL_LEN-1:0]  r_rd_sel;

    logic                w_clearing;
    logic                w_rd;
    logic                w_wr;
    logic [c_nbank-1:0]  w_sel_oh;
    logic [DATA_LEN-1:0] w_bank_rdata [c_nbank];
    logic [DATA_LEN-1:0] w_rd_mux;

    assign w_clearing = (r_state == ST_CLEAR);
    assign w_rd       = (r_state == ST_SERVE) && (rw == RW_READ);
    assign w_wr       = (r_state == ST_SERVE) && (rw == RW_WRITE);

    // One-hot bank select decode
    always_comb begin
        w_sel_oh      = '0;
        w_sel_oh[sel] = 1'b1;
    end

    genvar b;
    generate
        for (b = 0; b < c_nbank; b++) begin : g_bank
            bnn_mem_bank #(
                .ADDR_LEN (ADDR_LEN),
                .DATA_LEN (DATA_LEN)
            ) u_bank (
                .clk      (clk),
                .rst      (rst),
                .clr_en   (w_clearing),
                .clr_addr (r_clr_cnt),
                .we       (w_wr && w_sel_oh[b]),
                .re       (w_rd && w_sel_oh[b]),
                .addr     (addr),
                .wdata    (wdata),
                .rdata    (w_bank_rdata[b])
            );
        end
    endgenerate

    // FSM, clear counter, command decode and err/valid pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_sel  <= '0;
        end else begin
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    // Commands are not accepted while zero-filling
                    if (rw != RW_IDLE) begin
                        r_err <= 1'b1;
                    end
                    if (&r_clr_cnt) begin
                        r_state <= ST_SERVE;
                        r_ready <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    case (rw)
                        RW_READ: begin
                            r_rd_vld <= 1'b1;
                            r_rd_sel <= sel;
                        end
                        RW_RSVD: begin
                            r_err <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bank outputs only change on a read, so this mux holds between reads
    assign w_rd_mux = w_bank_rdata[r_rd_sel];

`ifdef MEM_READ_PIPE2_EN
    logic [DATA_LEN-1:0] r_rdata2;
    logic                r_vld2;

    // Second output stage: the captured word is immune to a following write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata2 <= '0;
            r_vld2   <= 1'b0;
        end else begin
            r_vld2 <= r_rd_vld;
            if (r_rd_vld) begin
                r_rdata2 <= w_rd_mux;
            end
        end
    end

    assign rdata       = r_rdata2;
    assign rdata_valid = r_vld2;
`else
    assign rdata       = w_rd_mux;
    assign rdata_valid = r_rd_vld;
`endif

    assign ready = r_ready;
    assign err   = r_err;

endmodule : bnn_mem_responder

`default_nettype wire
